adder_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface. It is the successor to the fixed 16-bit combinational adder: width and pipeline depth are generic, it adds a subtract mode and backpressure, and it offers optional signed saturation. It sits in the datapath wherever the single-cycle adder breaks timing at wide widths.

---
 rtl/adder_pipe_pkg.sv | 16 +
 rtl/adder_pipe_if.sv | 26 ++
 rtl/adder_pipe_stage.sv | 52 +++++
 rtl/adder_pipe.sv | 97 +++++++++
 tb/tb_adder_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared definitions for adder_pipe: op encodings, carry-chunk sizing and the
// legality check used at elaboration.
package adder_pipe_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_width(int width, int stages);
        return (stages >= 1) ? width / stages : width;
    endfunction

    function automatic bit cfg_ok(int width, int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result stream bundle for adder_pipe: valid/ready on both sides.
interface adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/adder_pipe_stage.sv
// One carry chunk of the pipelined adder: adds chunk IDX with the incoming carry
// and forwards operands, completed result bits, carry and valid to the next stage.
module adder_pipe_stage #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             prev_valid,
    input  logic             prev_carry,
    input  logic [WIDTH-1:0] prev_a,
    input  logic [WIDTH-1:0] prev_b,
    input  logic [WIDTH-1:0] prev_res,
    output logic             valid,
    output logic             carry,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] res
);

    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] res_next;

    // NOTE: every always_comb target gets a value before any condition, so no latch can form.
    always_comb begin
        part = {1'b0, prev_a[IDX*CHUNK +: CHUNK]}
             + {1'b0, prev_b[IDX*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, prev_carry};
        res_next = prev_res;
        res_next[IDX*CHUNK +: CHUNK] = part[CHUNK-1:0];
    end

    // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
        end else if (advance) begin
            valid <= prev_valid;
            carry <= part[CHUNK];
            op_a  <= prev_a;
            op_b  <= prev_b;
            res   <= res_next;
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract with valid/ready stream and global stall.
// Optional signed saturation of the result: define ADDER_PIPE_SAT_EN.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    adder_pipe_if.slave  bus
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("adder_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] a_front;
    logic [WIDTH-1:0] b_front;
    logic             c_front;

    logic             v_pipe [STAGES+1];
    logic             c_pipe [STAGES+1];
    logic [WIDTH-1:0] a_pipe [STAGES+1];
    logic [WIDTH-1:0] b_pipe [STAGES+1];
    logic [WIDTH-1:0] r_pipe [STAGES+1];

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    // Bubbles enter as zero operands so an idle pipeline presents all-zero outputs.
    always_comb begin
        a_front = '0;
        b_front = '0;
        c_front = 1'b0;
        if (accept) begin
            a_front = bus.a;
            b_front = (bus.op == OP_ADD) ? bus.b : ~bus.b;
            c_front = (bus.op == OP_SUB) ? ~bus.cin : bus.cin;
        end
    end

    assign v_pipe[0] = accept;
    assign c_pipe[0] = c_front;
    assign a_pipe[0] = a_front;
    assign b_pipe[0] = b_front;
    assign r_pipe[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .advance    (advance),
            .prev_valid (v_pipe[k]),
            .prev_carry (c_pipe[k]),
            .prev_a     (a_pipe[k]),
            .prev_b     (b_pipe[k]),
            .prev_res   (r_pipe[k]),
            .valid      (v_pipe[k+1]),
            .carry      (c_pipe[k+1]),
            .op_a       (a_pipe[k+1]),
            .op_b       (b_pipe[k+1]),
            .res        (r_pipe[k+1])
        );
    end

    // The forwarded operand MSBs of the last stage decide signed overflow.
    logic [WIDTH-1:0] raw;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;

    assign raw   = r_pipe[STAGES];
    assign a_msb = a_pipe[STAGES][WIDTH-1];
    assign b_msb = b_pipe[STAGES][WIDTH-1];
    assign ovf   = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);

    assign bus.out_valid = v_pipe[STAGES];
    assign bus.cout      = c_pipe[STAGES];
    assign bus.overflow  = ovf;

`ifdef ADDER_PIPE_SAT_EN
    assign bus.sum = ovf ? {a_msb, {(WIDTH-1){~a_msb}}} : raw;
`else
    assign bus.sum = raw;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (WIDTH 16, STAGES 4) against an arithmetic
// reference model; directed boundary cases, backpressure, reset and random traffic.
module tb_adder_pipe;
    import adder_pipe_pkg::*;

`ifdef ADDER_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int N_RANDOM = 10000;

    typedef struct packed {
        logic        cout;
        logic        ovf;
        logic [15:0] sum;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    adder_pipe_if #(.WIDTH(16)) bus ();

    adder_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic op);
        res_t r;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int ci = int'(cin);
        int ur;
        int sr;
        if (op == OP_ADD) begin
            ur     = ua + ub + ci;
            sr     = sa + sb + ci;
            r.cout = (ur > 65535);
        end else begin
            ur     = ua - ub - ci;
            sr     = sa - sb - ci;
            r.cout = (ur >= 0);
        end
        r.sum = ur[15:0];
        r.ovf = (sr > 32767) || (sr < -32768);
        if (SAT && r.ovf) r.sum = (sa >= 0) ? 16'h7FFF : 16'h8000;
        return r;
    endfunction

    task automatic drive(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input logic io, input logic ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.cin       = ic;
        bus.op        = io;
        bus.out_ready = ordy;
        #1;
    endtask

    // Sends one beat into an empty pipeline; lat counts rising edges from accept to out_valid.
    task automatic run_beat(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                            input logic io, output res_t obs, output int lat);
        obs = '0;
        lat = -1;
        drive(1'b1, ia, ib, ic, io, 1'b1);
        for (int n = 1; n <= 20; n++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (bus.out_valid === 1'b1) begin
                obs.sum  = bus.sum;
                obs.cout = bus.cout;
                obs.ovf  = bus.overflow;
                lat      = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_low: got %b expected 0", bus.in_ready);
        end
        checks++;
        if ({bus.out_valid, bus.cout, bus.overflow, bus.sum} !== 19'h0) begin
            errors++; $display("FAIL reset_outputs: got valid=%b cout=%b ovf=%b sum=%h expected all 0",
                               bus.out_valid, bus.cout, bus.overflow, bus.sum);
        end
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_add_boundary();
        res_t obs;
        int   lat;
        run_beat(16'h7FFF, 16'h0001, 1'b0, OP_ADD, obs, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL add_boundary_latency: got %0d expected 4", lat); end
        checks++;
        if (obs.sum !== (SAT ? 16'h7FFF : 16'h8000)) begin
            errors++; $display("FAIL add_boundary_sum: got %h expected %h", obs.sum, SAT ? 16'h7FFF : 16'h8000);
        end
        checks++;
        if (obs.cout !== 1'b0) begin errors++; $display("FAIL add_boundary_cout: got %b expected 0", obs.cout); end
        checks++;
        if (obs.ovf !== 1'b1) begin errors++; $display("FAIL add_boundary_ovf: got %b expected 1", obs.ovf); end
    endtask

    task automatic test_neg_overflow();
        res_t obs;
        int   lat;
        run_beat(16'h8000, 16'h8000, 1'b0, OP_ADD, obs, lat);
        checks++;
        if (obs !== {1'b1, 1'b1, (SAT ? 16'h8000 : 16'h0000)} || lat !== 4) begin
            errors++; $display("FAIL neg_overflow: got cout=%b ovf=%b sum=%h lat=%0d expected cout=1 ovf=1 sum=%h lat=4",
                               obs.cout, obs.ovf, obs.sum, lat, SAT ? 16'h8000 : 16'h0000);
        end
        run_beat(16'hFFFF, 16'hFFFF, 1'b1, OP_ADD, obs, lat);
        checks++;
        if (obs !== {1'b1, 1'b0, 16'hFFFF}) begin
            errors++; $display("FAIL carry_all_ones: got cout=%b ovf=%b sum=%h expected cout=1 ovf=0 sum=ffff",
                               obs.cout, obs.ovf, obs.sum);
        end
    endtask

    task automatic test_subtract();
        res_t obs;
        int   lat;
        run_beat(16'h0000, 16'h0001, 1'b0, OP_SUB, obs, lat);
        checks++;
        if (obs !== {1'b0, 1'b0, 16'hFFFF} || lat !== 4) begin
            errors++; $display("FAIL sub_borrow: got cout=%b ovf=%b sum=%h lat=%0d expected cout=0 ovf=0 sum=ffff lat=4",
                               obs.cout, obs.ovf, obs.sum, lat);
        end
        run_beat(16'h8000, 16'h0001, 1'b0, OP_SUB, obs, lat);
        checks++;
        if (obs !== {1'b1, 1'b1, (SAT ? 16'h8000 : 16'h7FFF)}) begin
            errors++; $display("FAIL sub_overflow: got cout=%b ovf=%b sum=%h expected cout=1 ovf=1 sum=%h",
                               obs.cout, obs.ovf, obs.sum, SAT ? 16'h8000 : 16'h7FFF);
        end
        run_beat(16'h1234, 16'h0234, 1'b1, OP_SUB, obs, lat);
        checks++;
        if (obs !== {1'b1, 1'b0, 16'h0FFF}) begin
            errors++; $display("FAIL sub_with_borrow_in: got cout=%b ovf=%b sum=%h expected cout=1 ovf=0 sum=0fff",
                               obs.cout, obs.ovf, obs.sum);
        end
    endtask

    task automatic test_backpressure();
        res_t q[$];
        res_t exp;
        res_t obs;
        res_t held = '0;
        logic prev_hold = 1'b0;
        logic ordy;
        logic iv;
        logic [15:0] ra, rb;
        logic rc, ro;
        int sent = 0;
        int got = 0;
        for (int t = 0; t < 60 && got < 8; t++) begin
            ordy = !(t >= 5 && t < 10);
            iv   = (sent < 8);
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); ro = 1'($urandom);
            drive(iv, ra, rb, rc, ro, ordy);
            obs = {bus.cout, bus.overflow, bus.sum};
            if (prev_hold) begin
                checks++;
                if (obs !== held || bus.out_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_held_output: got valid=%b %h expected valid=1 %h", bus.out_valid, obs, held);
                end
            end
            if (!ordy && bus.out_valid === 1'b1) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready_hold: got %b expected 0", bus.in_ready);
                end
            end
            if (bus.out_valid === 1'b1 && ordy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_unexpected_output: got %h expected no output", obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        errors++; $display("FAIL bp_result_%0d: got %h expected %h", got, obs, exp);
                    end
                end
                got++;
            end
            if (iv && bus.in_ready === 1'b1) begin
                q.push_back(model(ra, rb, rc, ro));
                sent++;
            end
            prev_hold = (bus.out_valid === 1'b1) && !ordy;
            held      = obs;
        end
        checks++;
        if (got !== 8 || sent !== 8 || q.size() !== 0) begin
            errors++; $display("FAIL bp_count: got %0d results of %0d sent (%0d pending) expected 8 of 8",
                               got, sent, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        res_t obs;
        res_t exp;
        int   lat;
        int   seen = 0;
        logic [15:0] ra, rb;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 16'($urandom), 16'($urandom), 1'b0, OP_ADD, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_in_ready: got %b expected 0", bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.cout, bus.overflow, bus.sum} !== 19'h0) begin
            errors++; $display("FAIL midreset_outputs: got valid=%b cout=%b ovf=%b sum=%h expected all 0",
                               bus.out_valid, bus.cout, bus.overflow, bus.sum);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL midreset_flushed: got %0d stale outputs expected 0", seen);
        end
        ra = 16'($urandom);
        rb = 16'($urandom);
        exp = model(ra, rb, 1'b1, OP_SUB);
        run_beat(ra, rb, 1'b1, OP_SUB, obs, lat);
        checks++;
        if (obs !== exp || lat !== 4) begin
            errors++; $display("FAIL midreset_next_beat: got %h lat=%0d expected %h lat=4", obs, lat, exp);
        end
    endtask

    task automatic test_random();
        res_t q[$];
        res_t exp;
        res_t obs;
        res_t held = '0;
        logic prev_hold = 1'b0;
        logic iv, ordy, rc, ro;
        logic [15:0] ra, rb;
        int sent = 0;
        int got = 0;
        for (int cyc = 0; cyc < 60000 && (sent < N_RANDOM || q.size() > 0); cyc++) begin
            iv   = (sent < N_RANDOM) && ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); ro = 1'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'h7FFF;
            if ($urandom_range(0, 7) == 0) rb = 16'h8000;
            drive(iv, ra, rb, rc, ro, ordy);
            obs = {bus.cout, bus.overflow, bus.sum};
            checks++;
            if (bus.in_ready !== (!bus.out_valid || ordy)) begin
                errors++; $display("FAIL rand_in_ready: got %b expected %b", bus.in_ready, !bus.out_valid || ordy);
            end
            if (prev_hold) begin
                checks++;
                if (obs !== held || bus.out_valid !== 1'b1) begin
                    errors++; $display("FAIL rand_held_output: got valid=%b %h expected valid=1 %h",
                                       bus.out_valid, obs, held);
                end
            end
            if (bus.out_valid === 1'b1 && ordy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected_output: got %h expected no output", obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        errors++; $display("FAIL rand_result_%0d: got cout=%b ovf=%b sum=%h expected cout=%b ovf=%b sum=%h",
                                           got, obs.cout, obs.ovf, obs.sum, exp.cout, exp.ovf, exp.sum);
                    end
                end
                got++;
            end
            if (iv && bus.in_ready === 1'b1) begin
                q.push_back(model(ra, rb, rc, ro));
                sent++;
            end
            prev_hold = (bus.out_valid === 1'b1) && !ordy;
            held      = obs;
        end
        checks++;
        if (sent !== N_RANDOM || got !== N_RANDOM || q.size() !== 0) begin
            errors++; $display("FAIL rand_completion: got %0d results of %0d sent (%0d pending) expected %0d",
                               got, sent, q.size(), N_RANDOM);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.op        = OP_ADD;
        bus.out_ready = 1'b1;
        test_reset();
        test_add_boundary();
        test_neg_overflow();
        test_subtract();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
